irq_priority_encoder: RTL and testbench

//   Parametrised, registered priority encoder with per-line pending latches and a

---
 rtl/irq_priority_encoder_if.sv | 11 +
 rtl/irq_priority_encoder.sv | 104 ++++++++++
 tb/tb_irq_priority_encoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_priority_encoder_if.sv
// rtl/irq_priority_encoder_if.sv - grant handshake bundle for the irq priority encoder
interface irq_priority_encoder_if #(
    parameter int IDX_W = 4
);
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_ready;

    modport master (output grant_valid, output grant_idx, input grant_ready);
    modport slave  (input grant_valid, input grant_idx, output grant_ready);
endinterface

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - registered priority encoder with pending latches and grant handshake
module irq_priority_encoder #(
    parameter int N         = 16,
    parameter int IDX_W     = 4,
    parameter bit EDGE_MODE = 1'b1,
    parameter bit PRIO_HIGH = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N-1:0]                  req_in,
    input  logic [N-1:0]                  mask,
    input  logic                          clear,
    irq_priority_encoder_if.master        grant,
    output logic [N-1:0]                  pending,
    output logic                          multi
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           state, state_next;
    logic [N-1:0]     cand;
    logic [IDX_W-1:0] sel;
    logic             load_idx;
    logic             ack;
    logic [N-1:0]     ack_vec;

    assign cand    = pending & ~mask;
    assign ack_vec = ack ? (N'(1) << grant.grant_idx) : '0;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (PRIO_HIGH) begin
                if (cand[i]) sel = IDX_W'(i);
            end else begin
                if (cand[N-1-i]) sel = IDX_W'(N - 1 - i);
            end
        end
    end

    always_comb begin
        state_next = state;
        load_idx   = 1'b0;
        ack        = 1'b0;
        case (state)
            IDLE: begin
                if (!clear && (cand != '0)) begin
                    state_next = OFFER;
                    load_idx   = 1'b1;
                end
            end
            OFFER: begin
                // clear wins over the handshake so a flushed offer never acks
                if (clear) begin
                    state_next = IDLE;
                end else if (grant.grant_ready) begin
                    state_next = IDLE;
                    ack        = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            grant.grant_idx <= '0;
            multi           <= 1'b0;
        end else begin
            state <= state_next;
            multi <= ((cand & (cand - N'(1))) != '0);
            if (load_idx) grant.grant_idx <= sel;
        end
    end

    assign grant.grant_valid = (state == OFFER);

    generate
        if (EDGE_MODE) begin : g_edge
            logic [N-1:0] req_q;
            logic [N-1:0] set_vec;

            assign set_vec = req_in & ~req_q;

            // a fresh edge outranks the ack of the same line, so it is never dropped
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    req_q   <= '0;
                    pending <= '0;
                end else begin
                    req_q   <= req_in;
                    pending <= clear ? '0 : ((pending & ~ack_vec) | set_vec);
                end
            end
        end else begin : g_level
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pending <= '0;
                else        pending <= clear ? '0 : req_in;
            end
        end
    endgenerate

endmodule

// File: tb/tb_irq_priority_encoder.sv
// tb/tb_irq_priority_encoder.sv - randomized model-checked bench over several encoder configurations
module tb_irq_priority_encoder;

    localparam int ND = 5;

    typedef struct {
        logic [15:0] pend;
        logic [15:0] reqq;
        bit          valid;
        int          idx;
        bit          multi;
    } mdl_t;

    int cfg_n    [ND] = '{16, 16, 4, 16, 4};
    bit cfg_edge [ND] = '{1, 1, 1, 0, 1};
    bit cfg_hi   [ND] = '{0, 1, 0, 0, 1};

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] msk;
    logic        clr;
    logic        rdy;

    logic [15:0] pend_o  [ND];
    logic        valid_o [ND];
    logic [3:0]  idx_o   [ND];
    logic        multi_o [ND];

    int checks;
    int failures;
    mdl_t m [ND];

    irq_priority_encoder_if #(.IDX_W(4)) g0 ();
    irq_priority_encoder_if #(.IDX_W(4)) g1 ();
    irq_priority_encoder_if #(.IDX_W(2)) g2 ();
    irq_priority_encoder_if #(.IDX_W(4)) g3 ();
    irq_priority_encoder_if #(.IDX_W(2)) g4 ();

    logic [15:0] p0, p1, p3;
    logic [3:0]  p2, p4;
    logic        mu0, mu1, mu2, mu3, mu4;

    irq_priority_encoder #(.N(16), .IDX_W(4), .EDGE_MODE(1'b1), .PRIO_HIGH(1'b0)) d0 (
        .clk(clk), .rst_n(rst_n), .req_in(req), .mask(msk), .clear(clr),
        .grant(g0), .pending(p0), .multi(mu0));
    irq_priority_encoder #(.N(16), .IDX_W(4), .EDGE_MODE(1'b1), .PRIO_HIGH(1'b1)) d1 (
        .clk(clk), .rst_n(rst_n), .req_in(req), .mask(msk), .clear(clr),
        .grant(g1), .pending(p1), .multi(mu1));
    irq_priority_encoder #(.N(4), .IDX_W(2), .EDGE_MODE(1'b1), .PRIO_HIGH(1'b0)) d2 (
        .clk(clk), .rst_n(rst_n), .req_in(req[3:0]), .mask(msk[3:0]), .clear(clr),
        .grant(g2), .pending(p2), .multi(mu2));
    irq_priority_encoder #(.N(16), .IDX_W(4), .EDGE_MODE(1'b0), .PRIO_HIGH(1'b0)) d3 (
        .clk(clk), .rst_n(rst_n), .req_in(req), .mask(msk), .clear(clr),
        .grant(g3), .pending(p3), .multi(mu3));
    irq_priority_encoder #(.N(4), .IDX_W(2), .EDGE_MODE(1'b1), .PRIO_HIGH(1'b1)) d4 (
        .clk(clk), .rst_n(rst_n), .req_in(req[3:0]), .mask(msk[3:0]), .clear(clr),
        .grant(g4), .pending(p4), .multi(mu4));

    assign g0.grant_ready = rdy;
    assign g1.grant_ready = rdy;
    assign g2.grant_ready = rdy;
    assign g3.grant_ready = rdy;
    assign g4.grant_ready = rdy;

    always_comb begin
        pend_o[0] = p0;            valid_o[0] = g0.grant_valid; idx_o[0] = g0.grant_idx;          multi_o[0] = mu0;
        pend_o[1] = p1;            valid_o[1] = g1.grant_valid; idx_o[1] = g1.grant_idx;          multi_o[1] = mu1;
        pend_o[2] = {12'b0, p2};   valid_o[2] = g2.grant_valid; idx_o[2] = {2'b0, g2.grant_idx};  multi_o[2] = mu2;
        pend_o[3] = p3;            valid_o[3] = g3.grant_valid; idx_o[3] = g3.grant_idx;          multi_o[3] = mu3;
        pend_o[4] = {12'b0, p4};   valid_o[4] = g4.grant_valid; idx_o[4] = {2'b0, g4.grant_idx};  multi_o[4] = mu4;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: one clock of the encoder from the rules, line by line.
    function automatic mdl_t step(input mdl_t s, input int n, input bit em, input bit hi,
                                  input logic [15:0] rq, input logic [15:0] mk,
                                  input bit cl, input bit rd);
        mdl_t        r;
        logic [15:0] wm;
        int          cnt;
        int          best;
        bit          acked;
        r    = s;
        wm   = (n == 16) ? 16'hffff : 16'((32'd1 << n) - 1);
        cnt  = 0;
        best = -1;
        for (int i = 0; i < n; i++) begin
            if (s.pend[i] && !mk[i]) begin
                cnt++;
                if (hi || best < 0) best = i;
            end
        end
        r.multi = (cnt >= 2);
        acked   = s.valid && rd && !cl;
        if (em) begin
            for (int i = 0; i < n; i++) begin
                if (cl)                        r.pend[i] = 1'b0;
                else if (rq[i] && !s.reqq[i])  r.pend[i] = 1'b1;
                else if (acked && s.idx == i)  r.pend[i] = 1'b0;
            end
            r.reqq = rq & wm;
        end else begin
            r.pend = cl ? 16'h0 : (rq & wm);
        end
        if (!s.valid) begin
            if (!cl && best >= 0) begin
                r.valid = 1'b1;
                r.idx   = best;
            end
        end else if (cl || rd) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

    task automatic reset_models();
        for (int k = 0; k < ND; k++) begin
            m[k].pend  = '0;
            m[k].reqq  = '0;
            m[k].valid = 1'b0;
            m[k].idx   = 0;
            m[k].multi = 1'b0;
        end
    endtask

    task automatic compare_all(input string phase);
        for (int k = 0; k < ND; k++) begin
            check($sformatf("%s_d%0d_valid", phase, k), 32'(valid_o[k]), 32'(m[k].valid));
            check($sformatf("%s_d%0d_idx", phase, k),   32'(idx_o[k]),   32'(m[k].idx));
            check($sformatf("%s_d%0d_pending", phase, k), 32'(pend_o[k]), 32'(m[k].pend));
            check($sformatf("%s_d%0d_multi", phase, k), 32'(multi_o[k]), 32'(m[k].multi));
        end
    endtask

    initial begin
        int next_rst;
        int dens;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        req   = '0;
        msk   = '0;
        clr   = 1'b0;
        rdy   = 1'b0;
        reset_models();
        #1;
        compare_all("reset");
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        next_rst = 400;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            compare_all("run");

            if (cyc >= next_rst && m[0].valid) begin
                // asynchronous reset while an offer is open must clear outputs before any edge
                rst_n = 1'b0;
                #1;
                reset_models();
                compare_all("async_rst");
                @(negedge clk);
                compare_all("in_rst");
                rst_n    = 1'b1;
                next_rst = next_rst + 600;
            end

            dens = (cyc / 250) % 4;
            case (dens)
                0: req = 16'($urandom & $urandom & $urandom);
                1: req = 16'($urandom & $urandom);
                2: req = (($urandom % 4) == 0) ? 16'(16'h1 << ($urandom % 16)) : 16'h0;
                default: req = (($urandom % 8) == 0) ? 16'h8001 : req;
            endcase
            msk = ((cyc / 125) % 2 == 1) ? 16'($urandom & $urandom & $urandom) : 16'h0;
            clr = (($urandom % 40) == 0);
            rdy = ((cyc / 60) % 3 == 0) ? 1'b1 : 1'(($urandom % 3) == 0);

            for (int k = 0; k < ND; k++)
                m[k] = step(m[k], cfg_n[k], cfg_edge[k], cfg_hi[k], req, msk, clr, rdy);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
